bram_sdp_be: RTL and testbench

- Next-generation simple dual-port block RAM wrapper: port A write-only, port B read-only, one clock.
- Adds per-byte write strobes, selectable read latency (1 or 2), a read-valid output and an optional clear-on-reset sequencer that fills every line with a constant.
- Keeps the same-cycle read-during-write forwarding, now merged per byte.
- Backing store for cache tag/data arrays and predictor tables that need byte-granular updates and a known post-reset state.

---
 rtl/bram_sdp_be.sv | 147 ++++++++++++++
 tb/tb_bram_sdp_be.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_be.sv
// Simple dual-port block RAM with byte strobes, 1- or 2-cycle read latency,
// same-edge per-byte write-first forwarding and an optional post-reset clear.
module bram_sdp_be #(
    parameter int unsigned           LINE_WIDTH    = 32,
    parameter int unsigned           BYTE_WIDTH    = 8,
    parameter int unsigned           DEPTH         = 128,
    parameter int unsigned           READ_LATENCY  = 1,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [LINE_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wen,
    input  logic [LINE_WIDTH/BYTE_WIDTH-1:0] wstrb,
    input  logic [$clog2(DEPTH)-1:0]         waddr,
    input  logic [LINE_WIDTH-1:0]            wline,
    input  logic                             ren,
    input  logic [$clog2(DEPTH)-1:0]         raddr,
    output logic [LINE_WIDTH-1:0]            rline,
    output logic                             rvalid,
    output logic                             init_busy
);

    localparam int unsigned NB = LINE_WIDTH / BYTE_WIDTH;
    localparam int unsigned AW = $clog2(DEPTH);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("bram_sdp_be: READ_LATENCY must be 1 or 2");
    end
    if (LINE_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("bram_sdp_be: LINE_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bram_sdp_be: DEPTH must be a power of two, at least 2");
    end

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] mem_q [DEPTH];

    logic [NB-1:0]         mem_we;
    logic [AW-1:0]         mem_wa;
    logic [LINE_WIDTH-1:0] mem_wd;
    logic                  rd_acc;

    logic [LINE_WIDTH-1:0] arr_q, arr_d;
    logic [NB-1:0]         fwd_strb_q, fwd_strb_d;
    logic [LINE_WIDTH-1:0] fwd_line_q, fwd_line_d;
    logic                  v1_q, v1_d;
    logic                  v2_q, v2_d;
    logic [LINE_WIDTH-1:0] out_q, out_d;
    logic [LINE_WIDTH-1:0] merged;

    // Control FSM and write-port steering (clear sequencer owns port A in INIT)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_we  = '0;
        mem_wa  = waddr;
        mem_wd  = wline;
        rd_acc  = 1'b0;
        case (state_q)
            ST_INIT: begin
                mem_we = '1;
                mem_wa = cnt_q;
                mem_wd = INIT_VALUE;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                if (wen) begin
                    mem_we = wstrb;
                end
                rd_acc = ren;
            end
        endcase
        if (rst) begin
            mem_we = '0;
            rd_acc = 1'b0;
        end
    end

    // Read pipeline: array register, forwarding capture, optional output stage
    always_comb begin
        arr_d      = arr_q;
        fwd_strb_d = fwd_strb_q;
        fwd_line_d = fwd_line_q;
        v1_d       = rd_acc;
        v2_d       = v1_q;
        out_d      = out_q;
        if (rd_acc) begin
            arr_d      = mem_q[raddr];
            fwd_strb_d = (wen && (waddr == raddr)) ? wstrb : '0;
            fwd_line_d = wline;
        end
        for (int unsigned i = 0; i < NB; i++) begin
            merged[i*BYTE_WIDTH +: BYTE_WIDTH] = fwd_strb_q[i] ? fwd_line_q[i*BYTE_WIDTH +: BYTE_WIDTH]
                                                               : arr_q[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (v1_q) begin
            out_d = merged;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NB; i++) begin
            if (mem_we[i]) begin
                mem_q[mem_wa][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wd[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT_ON_RESET ? ST_INIT : ST_READY;
            cnt_q      <= '0;
            arr_q      <= '0;
            fwd_strb_q <= '0;
            fwd_line_q <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            arr_q      <= arr_d;
            fwd_strb_q <= fwd_strb_d;
            fwd_line_q <= fwd_line_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            out_q      <= out_d;
        end
    end

    assign rline     = (READ_LATENCY == 2) ? out_q : merged;
    assign rvalid    = (READ_LATENCY == 2) ? v2_q : v1_q;
    assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_bram_sdp_be.sv
// Self-checking bench for bram_sdp_be: latency-1 and latency-2 instances share stimulus
// and are compared against a queue-based behavioural memory model.
module tb_bram_sdp_be;

    localparam int DEPTH = 128;
    localparam logic [31:0] INIT_VALUE = 32'h0;

    logic        clk = 1'b0;
    logic        rst, wen, ren;
    logic [3:0]  wstrb;
    logic [6:0]  waddr, raddr;
    logic [31:0] wline;
    logic [31:0] rline1, rline2;
    logic        rvalid1, rvalid2, busy1, busy2;

    int checks = 0;
    int errors = 0;

    bram_sdp_be #(.READ_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .wen(wen), .wstrb(wstrb), .waddr(waddr), .wline(wline),
        .ren(ren), .raddr(raddr), .rline(rline1), .rvalid(rvalid1), .init_busy(busy1)
    );

    bram_sdp_be #(.READ_LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .wen(wen), .wstrb(wstrb), .waddr(waddr), .wline(wline),
        .ren(ren), .raddr(raddr), .rline(rline2), .rvalid(rvalid2), .init_busy(busy2)
    );

    always #5 clk = ~clk;

    // Reference model: memory array, clear progress, and queues of pending read results
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] m_mem [DEPTH];
    logic        m_busy = 1'b1;
    int          m_cnt  = 0;
    int          cyc    = 0;
    rd_t         q1 [$];
    rd_t         q2 [$];
    logic        m_rv1 = 1'b0, m_rv2 = 1'b0;
    logic [31:0] m_rl1 = '0, m_rl2 = '0;

    task automatic tick();
        logic [31:0] d;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            q1.delete();
            q2.delete();
        end else if (m_busy) begin
            m_mem[m_cnt] = INIT_VALUE;
            if (m_cnt == DEPTH - 1) m_busy = 1'b0;
            else m_cnt++;
        end else begin
            if (ren) begin
                d = m_mem[raddr];
                if (wen && waddr == raddr)
                    for (int i = 0; i < 4; i++) if (wstrb[i]) d[8*i +: 8] = wline[8*i +: 8];
                q1.push_back('{due: cyc, data: d});
                q2.push_back('{due: cyc + 1, data: d});
            end
            if (wen)
                for (int i = 0; i < 4; i++) if (wstrb[i]) m_mem[waddr][8*i +: 8] = wline[8*i +: 8];
        end
        if (rst) begin
            m_rv1 = 1'b0; m_rl1 = '0;
            m_rv2 = 1'b0; m_rl2 = '0;
        end else begin
            m_rv1 = 1'b0;
            if (q1.size() > 0 && q1[0].due == cyc) begin
                m_rv1 = 1'b1; m_rl1 = q1[0].data; void'(q1.pop_front());
            end
            m_rv2 = 1'b0;
            if (q2.size() > 0 && q2[0].due == cyc) begin
                m_rv2 = 1'b1; m_rl2 = q2[0].data; void'(q2.pop_front());
            end
        end
        #1;
    endtask

    task automatic drive(input logic we, input logic [3:0] st, input logic [6:0] wa,
                         input logic [31:0] wd, input logic re, input logic [6:0] ra);
        wen = we; wstrb = st; waddr = wa; wline = wd; ren = re; raddr = ra;
    endtask

    task automatic test_reset();
        drive(0, 4'h0, 7'd0, 32'h0, 0, 7'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got %b/%b want 1/1", busy1, busy2);
        end
        checks++;
        if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid: got %b/%b want 0/0", rvalid1, rvalid2);
        end
        checks++;
        if (rline1 !== 32'h0 || rline2 !== 32'h0) begin
            errors++; $display("FAIL reset_rline: got %h/%h want 0/0", rline1, rline2);
        end
    endtask

    task automatic test_init_ignore();
        int nb = 1;
        drive(1, 4'hF, 7'd9, 32'h5555AAAA, 1, 7'd0);
        for (int i = 0; i < DEPTH; i++) begin
            raddr = 7'($urandom);
            tick();
            if (busy1 === 1'b1) nb++;
            checks++;
            if (busy1 !== m_busy || busy2 !== m_busy) begin
                errors++; $display("FAIL init_busy[%0d]: got %b/%b want %b", i, busy1, busy2, m_busy);
            end
            checks++;
            if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin
                errors++; $display("FAIL init_rvalid[%0d]: got %b/%b want 0", i, rvalid1, rvalid2);
            end
        end
        checks++;
        if (nb != DEPTH) begin
            errors++; $display("FAIL init_busy_cycles: got %0d want %0d", nb, DEPTH);
        end
        drive(0, 4'h0, 7'd0, 32'h0, 0, 7'd0);
        tick();
        checks++;
        if (rvalid2 !== 1'b0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL init_last_read_dropped: rvalid2 %b busy %b want 0/0", rvalid2, busy1);
        end
        drive(0, 4'h0, 7'd0, 32'h0, 1, 7'd9);
        tick();
        checks++;
        if (rvalid1 !== 1'b1 || rline1 !== INIT_VALUE) begin
            errors++; $display("FAIL init_line9: got v=%b %h want v=1 %h", rvalid1, rline1, INIT_VALUE);
        end
        raddr = 7'd5;
        tick();
        checks++;
        if (rvalid1 !== 1'b1 || rline1 !== INIT_VALUE || rvalid2 !== 1'b1 || rline2 !== INIT_VALUE) begin
            errors++; $display("FAIL init_line5: got %b %h / %b %h want 1 %h", rvalid1, rline1, rvalid2, rline2, INIT_VALUE);
        end
        drive(0, 4'h0, 7'd0, 32'h0, 0, 7'd0);
        tick();
    endtask

    task automatic test_partial_write();
        drive(1, 4'hF, 7'd3, 32'h11223344, 0, 7'd0);
        tick();
        drive(1, 4'b0101, 7'd3, 32'hAABBCCDD, 0, 7'd0);
        tick();
        drive(0, 4'h0, 7'd0, 32'h0, 1, 7'd3);
        tick();
        checks++;
        if (rvalid1 !== 1'b1 || rline1 !== 32'h11BB33DD) begin
            errors++; $display("FAIL partial_l1: got v=%b %h want v=1 11bb33dd", rvalid1, rline1);
        end
        ren = 1'b0;
        tick();
        checks++;
        if (rvalid2 !== 1'b1 || rline2 !== 32'h11BB33DD || rvalid1 !== 1'b0) begin
            errors++; $display("FAIL partial_l2: got v2=%b %h v1=%b want 1 11bb33dd 0", rvalid2, rline2, rvalid1);
        end
    endtask

    task automatic test_forward();
        drive(1, 4'hF, 7'd7, 32'h0, 0, 7'd0);
        tick();
        drive(1, 4'b1100, 7'd7, 32'hCAFEF00D, 1, 7'd7);
        tick();
        checks++;
        if (rvalid1 !== 1'b1 || rline1 !== 32'hCAFE0000) begin
            errors++; $display("FAIL fwd_l1: got v=%b %h want v=1 cafe0000", rvalid1, rline1);
        end
        drive(1, 4'hF, 7'd7, 32'hFFFFFFFF, 0, 7'd0);
        tick();
        checks++;
        if (rvalid1 !== 1'b0 || rline1 !== 32'hCAFE0000 || rvalid2 !== 1'b1 || rline2 !== 32'hCAFE0000) begin
            errors++; $display("FAIL fwd_after_write: got %b %h / %b %h want 0 cafe0000 / 1 cafe0000",
                               rvalid1, rline1, rvalid2, rline2);
        end
        drive(0, 4'h0, 7'd0, 32'h0, 0, 7'd0);
        tick();
        tick();
        checks++;
        if (rline1 !== 32'hCAFE0000 || rline2 !== 32'hCAFE0000 || rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin
            errors++; $display("FAIL fwd_hold: got %b %h / %b %h want 0 cafe0000", rvalid1, rline1, rvalid2, rline2);
        end
        drive(0, 4'h0, 7'd0, 32'h0, 1, 7'd7);
        tick();
        checks++;
        if (rline1 !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL fwd_reread: got %h want ffffffff", rline1);
        end
        ren = 1'b0;
        tick();
    endtask

    task automatic test_latency2();
        logic        ev [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ed [5] = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h3};
        for (int a = 1; a <= 3; a++) begin
            drive(1, 4'hF, 7'(a), 32'(a), 0, 7'd0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'h0, 7'd0, 32'h0, (i < 3), 7'(i + 1));
            tick();
            checks++;
            if (rvalid2 !== ev[i] || (i > 0 && rline2 !== ed[i])) begin
                errors++; $display("FAIL lat2[%0d]: got v=%b %h want v=%b %h", i, rvalid2, rline2, ev[i], ed[i]);
            end
            checks++;
            if (rvalid1 !== m_rv1 || rline1 !== m_rl1) begin
                errors++; $display("FAIL lat1_b2b[%0d]: got v=%b %h want v=%b %h", i, rvalid1, rline1, m_rv1, m_rl1);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 4'($urandom), 7'($urandom_range(0, 7)), $urandom,
                  1'($urandom), 7'($urandom_range(0, 7)));
            tick();
            checks++;
            if (rvalid1 !== m_rv1 || rline1 !== m_rl1) begin
                errors++; $display("FAIL rand_l1[%0d]: got v=%b %h want v=%b %h", i, rvalid1, rline1, m_rv1, m_rl1);
            end
            checks++;
            if (rvalid2 !== m_rv2 || rline2 !== m_rl2) begin
                errors++; $display("FAIL rand_l2[%0d]: got v=%b %h want v=%b %h", i, rvalid2, rline2, m_rv2, m_rl2);
            end
        end
        drive(0, 4'h0, 7'd0, 32'h0, 0, 7'd0);
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int nb = 1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            tick();
            if (busy1 === 1'b1) nb++;
            checks++;
            if (busy1 !== m_busy || busy2 !== m_busy) begin
                errors++; $display("FAIL mid_busy[%0d]: got %b/%b want %b", i, busy1, busy2, m_busy);
            end
        end
        checks++;
        if (nb != DEPTH) begin
            errors++; $display("FAIL mid_busy_cycles: got %0d want %0d", nb, DEPTH);
        end
        drive(0, 4'h0, 7'd0, 32'h0, 1, 7'($urandom));
        tick();
        checks++;
        if (rvalid1 !== 1'b1) begin
            errors++; $display("FAIL mid_read_l1: got v=%b want 1", rvalid1);
        end
        ren = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rvalid2 !== 1'b0 || rline2 !== 32'h0 || rvalid1 !== 1'b0) begin
            errors++; $display("FAIL mid_read_discard: got v2=%b %h v1=%b want 0 0 0", rvalid2, rline2, rvalid1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            checks++;
            if (rvalid2 !== 1'b0 || rvalid1 !== 1'b0 || busy2 !== m_busy) begin
                errors++; $display("FAIL post_reset[%0d]: got v %b/%b busy %b want 0/0 %b", i, rvalid1, rvalid2, busy2, m_busy);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        rst = 1'b1;
        drive(0, 4'h0, 7'd0, 32'h0, 0, 7'd0);
        @(negedge clk);
        test_reset();
        test_init_ignore();
        test_partial_write();
        test_forward();
        test_latency2();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
